set_assoc_trace_cache: RTL and testbench

//  Parametrised N-way set-associative trace-driven cache engine; successor to the fixed split I/D caches.

---
 rtl/cache_pkg.sv | 29 ++
 rtl/lru_age_update.sv | 37 +++
 rtl/set_assoc_trace_cache.sv | 234 +++++++++++++++++++++++
 tb/tb_set_assoc_trace_cache.sv | 224 ++++++++++++++++++++++
 4 files changed

// File: rtl/cache_pkg.sv
// Shared definitions for the set-associative trace cache engine:
// trace command codes, FSM state encoding and address-split width helpers.
package cache_pkg;

  localparam logic [3:0] CMD_RD    = 4'd0;
  localparam logic [3:0] CMD_WR    = 4'd1;
  localparam logic [3:0] CMD_IF    = 4'd2;
  localparam logic [3:0] CMD_INV   = 4'd3;
  localparam logic [3:0] CMD_CLR   = 4'd8;
  localparam logic [3:0] CMD_PRINT = 4'd9;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOOKUP,
    S_WB,
    S_FILL,
    S_RESP
  } state_t;

  function automatic int tag_w(input int addr_w, input int sets_log2, input int line_log2);
    return addr_w - sets_log2 - line_log2;
  endfunction

  // age / way-index width; a direct-mapped cache still gets a 1-bit field
  function automatic int age_w(input int ways);
    return (ways > 1) ? $clog2(ways) : 1;
  endfunction

endpackage

// File: rtl/lru_age_update.sv
// True-LRU age update for one set (combinational).
// Ports:
//   ages     : current per-way ages (0 = most recent, WAYS-1 = least recent)
//   valid    : per-way valid bits, used for victim choice
//   acc_way  : way being accessed this cycle
//   new_ages : ages after touching acc_way
//   victim   : lowest-index invalid way, else the way whose age is WAYS-1
module lru_age_update #(
  parameter int WAYS = 4,
  parameter int AW   = 2
) (
  input  logic [WAYS-1:0][AW-1:0] ages,
  input  logic [WAYS-1:0]         valid,
  input  logic [AW-1:0]           acc_way,
  output logic [WAYS-1:0][AW-1:0] new_ages,
  output logic [AW-1:0]           victim
);

  logic [AW-1:0] acc_age;
  assign acc_age = ages[acc_way];

  // only ways younger than the touched one age; older ones keep their rank
  for (genvar i = 0; i < WAYS; i++) begin : g_age
    assign new_ages[i] = (AW'(i) == acc_way) ? '0 :
                         (ages[i] < acc_age) ? ages[i] + 1'b1 : ages[i];
  end

  // descending scans so the lowest index wins; invalid ways take priority
  always_comb begin
    victim = '0;
    for (int i = WAYS - 1; i >= 0; i--)
      if (ages[i] == AW'(WAYS - 1)) victim = AW'(i);
    for (int i = WAYS - 1; i >= 0; i--)
      if (!valid[i]) victim = AW'(i);
  end

endmodule

// File: rtl/set_assoc_trace_cache.sv
// N-way set-associative trace-driven cache engine (one instance per I or D side).
// Accepts one trace command per handshake, tracks tag/valid/dirty/LRU state in
// flops, issues write-back / fill line requests to the next level and keeps
// hit/miss/read/write statistics.
// Optional feature: define CACHE_STATS_EN to build the statistics counters and
// the stats_valid pulse; otherwise those outputs are tied to zero.
// Ports:
//   clk, clear          : clock, synchronous active-high reset
//   cmd_valid/cmd_ready : command handshake (ready only while idle)
//   n, add_in           : command code and byte address
//   add_out             : next-level line address
//   l2_req, l2_we       : next-level request (we=1 write-back, 0 fill), held until l2_ack
//   l2_ack              : next-level completion pulse
//   resp_valid/resp_hit : command-complete pulse and hit flag
//   stats_valid         : pulse on print command
//   hits/misses/reads/writes : saturating statistics counters
module set_assoc_trace_cache
  import cache_pkg::*;
#(
  parameter int WAYS      = 4,
  parameter int SETS_LOG2 = 4,
  parameter int LINE_LOG2 = 6,
  parameter int ADDR_W    = 32,
  parameter int CNT_W     = 32
) (
  input  logic                    clk,
  input  logic                    clear,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [3:0]              n,
  input  logic [ADDR_W-1:0]       add_in,
  output logic [ADDR_W-LINE_LOG2-1:0] add_out,
  output logic                    l2_req,
  output logic                    l2_we,
  input  logic                    l2_ack,
  output logic                    resp_valid,
  output logic                    resp_hit,
  output logic                    stats_valid,
  output logic [CNT_W-1:0]        hits,
  output logic [CNT_W-1:0]        misses,
  output logic [CNT_W-1:0]        reads,
  output logic [CNT_W-1:0]        writes
);

  localparam int TAG_W = tag_w(ADDR_W, SETS_LOG2, LINE_LOG2);
  localparam int AW    = age_w(WAYS);
  localparam int SETS  = 1 << SETS_LOG2;

  state_t                 state;
  logic [3:0]             cmd_q;
  logic [TAG_W-1:0]       tag_q;
  logic [SETS_LOG2-1:0]   set_q;
  logic [AW-1:0]          way_q;

  logic [SETS-1:0][WAYS-1:0][TAG_W-1:0] tags;
  logic [SETS-1:0][WAYS-1:0]            valid, dirty;
  logic [SETS-1:0][WAYS-1:0][AW-1:0]    ages;

  logic [WAYS-1:0]         hit_vec;
  logic                    hit;
  logic [AW-1:0]           hit_way, acc_way, victim;
  logic [WAYS-1:0][AW-1:0] new_ages;
  logic                    wipe_cmd;
  logic                    unused_offset;

  assign unused_offset = ^add_in[LINE_LOG2-1:0];

  for (genvar w = 0; w < WAYS; w++) begin : g_tag
    assign hit_vec[w] = valid[set_q][w] && (tags[set_q][w] == tag_q);
  end
  assign hit = |hit_vec;

  always_comb begin
    hit_way = '0;
    for (int w = WAYS - 1; w >= 0; w--)
      if (hit_vec[w]) hit_way = AW'(w);
  end

  // lookup touches the hit way; a fill touches the victim latched at lookup
  assign acc_way  = (state == S_LOOKUP) ? hit_way : way_q;
  assign wipe_cmd = (state == S_LOOKUP) && (cmd_q == CMD_CLR);

  lru_age_update #(.WAYS(WAYS), .AW(AW)) u_lru (
    .ages     (ages[set_q]),
    .valid    (valid[set_q]),
    .acc_way  (acc_way),
    .new_ages (new_ages),
    .victim   (victim)
  );

  always_ff @(posedge clk) begin
    if (clear) begin
      state      <= S_IDLE;
      cmd_ready  <= 1'b1;
      l2_req     <= 1'b0;
      l2_we      <= 1'b0;
      add_out    <= '0;
      resp_valid <= 1'b0;
      resp_hit   <= 1'b0;
      cmd_q      <= '0;
      tag_q      <= '0;
      set_q      <= '0;
      way_q      <= '0;
    end else begin
      resp_valid <= 1'b0;
      case (state)
        S_IDLE: if (cmd_valid) begin
          cmd_q     <= n;
          tag_q     <= add_in[ADDR_W-1 -: TAG_W];
          set_q     <= add_in[LINE_LOG2 +: SETS_LOG2];
          cmd_ready <= 1'b0;
          state     <= S_LOOKUP;
        end
        S_LOOKUP: begin
          resp_hit <= 1'b0;
          state    <= S_RESP;
          resp_valid <= 1'b1;
          case (cmd_q)
            CMD_RD, CMD_WR, CMD_IF: begin
              if (hit) begin
                resp_hit    <= 1'b1;
                ages[set_q] <= new_ages;
                if (cmd_q == CMD_WR) dirty[set_q][hit_way] <= 1'b1;
              end else begin
                resp_valid <= 1'b0;
                way_q      <= victim;
                l2_req     <= 1'b1;
                if (valid[set_q][victim] && dirty[set_q][victim]) begin
                  l2_we   <= 1'b1;
                  add_out <= {tags[set_q][victim], set_q};
                  state   <= S_WB;
                end else begin
                  l2_we   <= 1'b0;
                  add_out <= {tag_q, set_q};
                  state   <= S_FILL;
                end
              end
            end
            CMD_INV: begin
              resp_hit <= hit;
              if (hit && dirty[set_q][hit_way]) begin
                resp_valid <= 1'b0;
                way_q      <= hit_way;
                l2_req     <= 1'b1;
                l2_we      <= 1'b1;
                add_out    <= {tag_q, set_q};
                state      <= S_WB;
              end else if (hit) begin
                valid[set_q][hit_way] <= 1'b0;
              end
            end
            default: ;
          endcase
        end
        S_WB: if (l2_ack) begin
          l2_req <= 1'b0;
          l2_we  <= 1'b0;
          dirty[set_q][way_q] <= 1'b0;
          if (cmd_q == CMD_INV) begin
            valid[set_q][way_q] <= 1'b0;
            resp_valid <= 1'b1;
            state      <= S_RESP;
          end else begin
            state <= S_FILL;
          end
        end
        S_FILL: begin
          // after a write-back, l2_req is low for one cycle before the fill
          if (!l2_req) begin
            l2_req  <= 1'b1;
            l2_we   <= 1'b0;
            add_out <= {tag_q, set_q};
          end else if (l2_ack) begin
            l2_req <= 1'b0;
            tags[set_q][way_q]  <= tag_q;
            valid[set_q][way_q] <= 1'b1;
            dirty[set_q][way_q] <= (cmd_q == CMD_WR);
            ages[set_q]         <= new_ages;
            resp_valid          <= 1'b1;
            state               <= S_RESP;
          end
        end
        S_RESP: begin
          cmd_ready <= 1'b1;
          state     <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
    // placed last so it overrides any array update above
    if (clear || wipe_cmd) begin
      valid <= '0;
      dirty <= '0;
      for (int s = 0; s < SETS; s++)
        for (int w = 0; w < WAYS; w++)
          ages[s][w] <= AW'(w);
    end
  end

`ifdef CACHE_STATS_EN
  logic lookup_acc;
  assign lookup_acc = (state == S_LOOKUP) &&
                      (cmd_q == CMD_RD || cmd_q == CMD_WR || cmd_q == CMD_IF);

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

  always_ff @(posedge clk) begin
    if (clear || wipe_cmd) begin
      hits        <= '0;
      misses      <= '0;
      reads       <= '0;
      writes      <= '0;
      stats_valid <= 1'b0;
    end else begin
      stats_valid <= cmd_valid && cmd_ready && (n == CMD_PRINT);
      if (lookup_acc) begin
        if (hit) hits   <= sat_inc(hits);
        else     misses <= sat_inc(misses);
        if (cmd_q == CMD_WR) writes <= sat_inc(writes);
        else                 reads  <= sat_inc(reads);
      end
    end
  end
`else
  assign hits        = '0;
  assign misses      = '0;
  assign reads       = '0;
  assign writes      = '0;
  assign stats_valid = 1'b0;
`endif

endmodule

// File: tb/tb_set_assoc_trace_cache.sv
// Self-checking bench for set_assoc_trace_cache (WAYS=4, SETS_LOG2=4, LINE_LOG2=6).
// Table of trace commands with expected hit flag and next-level requests; the
// expectations go into scoreboard queues when a command is driven and are
// popped as the DUT raises l2_req / resp_valid.
module tb_set_assoc_trace_cache;

  localparam int ADDR_W = 32;
  localparam int LA_W   = 26;
  localparam int CNT_W  = 32;
`ifdef CACHE_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              clear, cmd_valid, l2_ack;
  logic              cmd_ready, l2_req, l2_we, resp_valid, resp_hit, stats_valid;
  logic [3:0]        cmd_n;
  logic [ADDR_W-1:0] add_in;
  logic [LA_W-1:0]   add_out;
  logic [CNT_W-1:0]  hits, misses, reads, writes;

  set_assoc_trace_cache #(
    .WAYS(4), .SETS_LOG2(4), .LINE_LOG2(6), .ADDR_W(ADDR_W), .CNT_W(CNT_W)
  ) dut (
    .clk(clk), .clear(clear), .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .n(cmd_n), .add_in(add_in), .add_out(add_out), .l2_req(l2_req), .l2_we(l2_we),
    .l2_ack(l2_ack), .resp_valid(resp_valid), .resp_hit(resp_hit),
    .stats_valid(stats_valid), .hits(hits), .misses(misses), .reads(reads),
    .writes(writes)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]      n;
    logic [31:0]     addr;
    bit              hit;
    bit              wb;
    logic [LA_W-1:0] wb_line;
    bit              fill;
    logic [LA_W-1:0] fill_line;
  } vec_t;

  typedef struct {
    bit              we;
    logic [LA_W-1:0] line;
  } l2_t;

  bit   exp_hit_q[$];
  l2_t  exp_l2_q[$];
  vec_t tbl[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   last_lat, last_sv;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic vec_t mk(input logic [3:0] n, input logic [31:0] a, input bit h,
                              input bit wb, input logic [LA_W-1:0] wl,
                              input bit f, input logic [LA_W-1:0] fl);
    vec_t v;
    v.n = n; v.addr = a; v.hit = h; v.wb = wb; v.wb_line = wl; v.fill = f; v.fill_line = fl;
    return v;
  endfunction

  task automatic run(input vec_t v);
    int  cyc;
    bit  done, eh;
    l2_t e;
    exp_hit_q.push_back(v.hit);
    if (v.wb)   begin e.we = 1'b1; e.line = v.wb_line;   exp_l2_q.push_back(e); end
    if (v.fill) begin e.we = 1'b0; e.line = v.fill_line; exp_l2_q.push_back(e); end
    cyc = 0;
    @(negedge clk);
    while (!cmd_ready && cyc < 100) begin @(negedge clk); cyc++; end
    if (!cmd_ready) check("ready_timeout", 0, 1);
    cmd_valid = 1'b1; cmd_n = v.n; add_in = v.addr;
    @(posedge clk); #1 cmd_valid = 1'b0;
    done = 1'b0; last_lat = -1; last_sv = -1; cyc = 0;
    while (!done && cyc < 200) begin
      @(negedge clk); cyc++;
      if (stats_valid && last_sv < 0) last_sv = cyc;
      if (resp_valid) begin
        if (exp_hit_q.size() == 0) check("resp_unexpected", 1, 0);
        else begin eh = exp_hit_q.pop_front(); check("resp_hit", resp_hit, eh); end
        check("l2_missing", exp_l2_q.size(), 0);
        exp_l2_q.delete();
        last_lat = cyc; done = 1'b1;
      end else if (l2_req) begin
        if (exp_l2_q.size() == 0) check("l2_unexpected", 1, 0);
        else begin
          e = exp_l2_q.pop_front();
          check("l2_we", l2_we, e.we);
          check("add_out", add_out, e.line);
        end
        l2_ack = 1'b1;
        @(posedge clk); #1 l2_ack = 1'b0;
      end
    end
    if (!done) begin
      check("resp_timeout", 0, 1);
      exp_hit_q.delete(); exp_l2_q.delete();
    end
    if (done && v.hit && v.n < 4'd3) check("hit_latency", last_lat, 2);
  endtask

  task automatic check_stats(input string tag, input int h, input int m, input int r, input int w);
    check({tag, "_hits"},   hits,   STATS ? h : 0);
    check({tag, "_misses"}, misses, STATS ? m : 0);
    check({tag, "_reads"},  reads,  STATS ? r : 0);
    check({tag, "_writes"}, writes, STATS ? w : 0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    bit seen_req, seen_resp;
    int cyc;
    clear = 1'b1; cmd_valid = 1'b0; cmd_n = '0; add_in = '0; l2_ack = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 1);
    check("rst_l2_req", l2_req, 0);
    check("rst_l2_we", l2_we, 0);
    check("rst_add_out", add_out, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_stats_valid", stats_valid, 0);
    check_stats("rst", 0, 0, 0, 0);
    clear = 1'b0;

    // cold miss then hit on the same line
    run(mk(4'd0, 32'h1000, 0, 0, 0, 1, 26'h40));
    run(mk(4'd0, 32'h1000, 1, 0, 0, 0, 0));
    check_stats("cold", 1, 1, 2, 0);

    // set-0 LRU walk, dirty victim write-back, invalidate variants, odd codes
    tbl.push_back(mk(4'd8, 32'h0,    0, 0, 0,     0, 0));
    tbl.push_back(mk(4'd0, 32'h0000, 0, 0, 0,     1, 26'h00));
    tbl.push_back(mk(4'd0, 32'h0400, 0, 0, 0,     1, 26'h10));
    tbl.push_back(mk(4'd0, 32'h0800, 0, 0, 0,     1, 26'h20));
    tbl.push_back(mk(4'd0, 32'h0C00, 0, 0, 0,     1, 26'h30));
    tbl.push_back(mk(4'd0, 32'h1000, 0, 0, 0,     1, 26'h40));
    tbl.push_back(mk(4'd0, 32'h0000, 0, 0, 0,     1, 26'h00));
    tbl.push_back(mk(4'd0, 32'h0400, 0, 0, 0,     1, 26'h10));
    tbl.push_back(mk(4'd0, 32'h0C00, 1, 0, 0,     0, 0));
    tbl.push_back(mk(4'd0, 32'h0800, 0, 0, 0,     1, 26'h20));
    tbl.push_back(mk(4'd0, 32'h1000, 0, 0, 0,     1, 26'h40));
    tbl.push_back(mk(4'd1, 32'h0000, 0, 0, 0,     1, 26'h00));
    tbl.push_back(mk(4'd0, 32'h4000, 0, 0, 0,     1, 26'h100));
    tbl.push_back(mk(4'd0, 32'h4400, 0, 0, 0,     1, 26'h110));
    tbl.push_back(mk(4'd0, 32'h4800, 0, 0, 0,     1, 26'h120));
    tbl.push_back(mk(4'd0, 32'h4C00, 0, 1, 26'h0, 1, 26'h130));
    tbl.push_back(mk(4'd1, 32'h2040, 0, 0, 0,     1, 26'h81));
    tbl.push_back(mk(4'd3, 32'h2040, 1, 1, 26'h81, 0, 0));
    tbl.push_back(mk(4'd0, 32'h2040, 0, 0, 0,     1, 26'h81));
    tbl.push_back(mk(4'd3, 32'h2040, 1, 0, 0,     0, 0));
    tbl.push_back(mk(4'd3, 32'h3040, 0, 0, 0,     0, 0));
    tbl.push_back(mk(4'd0, 32'h2040, 0, 0, 0,     1, 26'h81));
    tbl.push_back(mk(4'd2, 32'h2040, 1, 0, 0,     0, 0));
    tbl.push_back(mk(4'd5, 32'h2040, 0, 0, 0,     0, 0));
    for (int i = 0; i < tbl.size(); i++) run(tbl[i]);

    // mixed trace: 3 rd, 2 wr, 1 ifetch, then print
    run(mk(4'd8, 32'h0,   0, 0, 0, 0, 0));
    check_stats("clr", 0, 0, 0, 0);
    run(mk(4'd0, 32'h100, 0, 0, 0, 1, 26'h4));
    run(mk(4'd0, 32'h100, 1, 0, 0, 0, 0));
    run(mk(4'd1, 32'h100, 1, 0, 0, 0, 0));
    run(mk(4'd1, 32'h140, 0, 0, 0, 1, 26'h5));
    run(mk(4'd0, 32'h180, 0, 0, 0, 1, 26'h6));
    run(mk(4'd2, 32'h100, 1, 0, 0, 0, 0));
    run(mk(4'd9, 32'h0,   0, 0, 0, 0, 0));
    check("stats_valid_cycle", last_sv, STATS ? 1 : -1);
    check_stats("mix", 3, 3, 4, 2);
    run(mk(4'd8, 32'h0,   0, 0, 0, 0, 0));
    check_stats("clr2", 0, 0, 0, 0);
    run(mk(4'd0, 32'h100, 0, 0, 0, 1, 26'h4));

    // clear while a fill is waiting for its ack
    @(negedge clk);
    cmd_valid = 1'b1; cmd_n = 4'd0; add_in = 32'h8000;
    @(posedge clk); #1 cmd_valid = 1'b0;
    cyc = 0;
    @(negedge clk);
    while (!l2_req && cyc < 20) begin @(negedge clk); cyc++; end
    check("abort_l2_req", l2_req, 1);
    check("abort_add_out", add_out, 26'h200);
    clear = 1'b1;
    @(posedge clk); #1 clear = 1'b0;
    @(negedge clk);
    check("abort_req_drop", l2_req, 0);
    check("abort_ready", cmd_ready, 1);
    l2_ack = 1'b1;
    @(posedge clk); #1 l2_ack = 1'b0;
    seen_req = 1'b0; seen_resp = 1'b0;
    repeat (3) begin
      @(negedge clk);
      if (l2_req) seen_req = 1'b1;
      if (resp_valid) seen_resp = 1'b1;
    end
    check("stale_ack_req", seen_req, 0);
    check("stale_ack_resp", seen_resp, 0);
    check("stale_ack_ready", cmd_ready, 1);
    run(mk(4'd0, 32'h100,  0, 0, 0, 1, 26'h4));
    run(mk(4'd0, 32'h8000, 0, 0, 0, 1, 26'h200));
    check_stats("post_abort", 0, 2, 2, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
